// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM-to-RAM loader: FSM state encoding and
// region-table field access.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_CAPT,
        ST_DONE
    } ld_state_t;

    // Each REG_AW table entry is a 5-bit region address width.
    localparam int unsigned REG_AW_FW = 5;
    localparam int unsigned MAX_REG   = 32;
    localparam int unsigned AW_TBL_W  = REG_AW_FW * MAX_REG;

    function automatic logic [REG_AW_FW-1:0] reg_aw_at(
        input logic [AW_TBL_W-1:0] tbl,
        input int unsigned         idx
    );
        return tbl[idx*REG_AW_FW +: REG_AW_FW];
    endfunction

endpackage

// File: rtl/rom_loader_decode.sv
// Combinational region decoder: maps a download address to a one-hot region
// match (lowest index wins on overlap) and the region-local address.
module rom_region_decode
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W  = 19,
    parameter int NUM_REG = 8,
    parameter logic [NUM_REG*ADDR_W-1:0]    REG_BASE = '0,
    parameter logic [NUM_REG*REG_AW_FW-1:0] REG_AW   = '0
) (
    input  logic [ADDR_W-1:0]  dl_addr,
    output logic [NUM_REG-1:0] match,
    output logic [13:0]        local_addr
);

    localparam logic [AW_TBL_W-1:0] AW_TBL = AW_TBL_W'(REG_AW);

    logic [REG_AW_FW-1:0] aw;
    logic [ADDR_W-1:0]    base;
    logic [ADDR_W-1:0]    lo_mask;
    logic                 found;

    always_comb begin
        match      = '0;
        local_addr = '0;
        found      = 1'b0;
        aw         = '0;
        base       = '0;
        lo_mask    = '0;
        for (int unsigned i = 0; i < NUM_REG; i++) begin
            aw   = reg_aw_at(AW_TBL, i);
            base = REG_BASE[i*ADDR_W +: ADDR_W];
            for (int unsigned b = 0; b < ADDR_W; b++)
                lo_mask[b] = (b < 32'(aw));
            // Only bits above the region width take part in the compare.
            if (!found && aw != '0 && ((dl_addr ^ base) & ~lo_mask) == '0) begin
                found      = 1'b1;
                match[i]   = 1'b1;
                local_addr = 14'(dl_addr & lo_mask);
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Copies external ROM bytes 0..END_ADDR into per-region RAMs, accumulating a
// 16-bit checksum, then hands the ROM address bus back to the game CPU.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8,
    parameter int NUM_REG = 8,
    parameter logic [NUM_REG*ADDR_W-1:0] REG_BASE = {
        19'h00000, 19'h10000, 19'h0C000, 19'h0B000,
        19'h0A000, 19'h08000, 19'h04000, 19'h00000},
    parameter logic [NUM_REG*REG_AW_FW-1:0] REG_AW = {
        5'd0, 5'd14, 5'd14, 5'd12, 5'd12, 5'd13, 5'd14, 5'd14},
    parameter logic [ADDR_W-1:0] END_ADDR = 19'h1FFFF,
    parameter int WAIT_CYC   = 1,
    parameter int AUTO_START = 1
) (
    input  logic                clk_6144,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cpu_a,
    output logic [ADDR_W-1:0]   rom_a,
    input  logic [DATA_W-1:0]   rom_d,
    output logic [13:0]         wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REG-1:0]  wr_en,
    output logic                busy,
    output logic                done,
    output logic [15:0]         checksum
);

    localparam logic [3:0] WAIT_M1 = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    ld_state_t           state, state_n;
    logic [ADDR_W-1:0]   dl_addr;
    logic [3:0]          wait_cnt;
    logic                auto_pend;
    logic                last_addr;
    logic                load_go;
    logic [NUM_REG-1:0]  dec_match;
    logic [13:0]         dec_local;

    rom_region_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REG  (NUM_REG),
        .REG_BASE (REG_BASE),
        .REG_AW   (REG_AW)
    ) u_decode (
        .dl_addr    (dl_addr),
        .match      (dec_match),
        .local_addr (dec_local)
    );

    assign last_addr = (dl_addr == END_ADDR);

    always_ff @(posedge clk_6144 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load_go = 1'b0;
        case (state)
            ST_IDLE: if (start || auto_pend) begin
                state_n = ST_ADDR;
                load_go = 1'b1;
            end
            ST_ADDR: state_n = (WAIT_CYC > 0) ? ST_WAIT : ST_CAPT;
            ST_WAIT: if (wait_cnt == '0) state_n = ST_CAPT;
            ST_CAPT: state_n = last_addr ? ST_DONE : ST_ADDR;
            ST_DONE: if (start) begin
                state_n = ST_ADDR;
                load_go = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy  = (state == ST_ADDR) || (state == ST_WAIT) || (state == ST_CAPT);
    assign done  = (state == ST_DONE);
    assign rom_a = busy ? dl_addr : cpu_a;

    always_ff @(posedge clk_6144 or posedge reset) begin
        if (reset) begin
            dl_addr   <= '0;
            wait_cnt  <= '0;
            auto_pend <= (AUTO_START != 0);
            wr_en     <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            checksum  <= '0;
        end else begin
            auto_pend <= 1'b0;
            wr_en     <= '0;
            if (load_go) begin
                dl_addr  <= '0;
                checksum <= '0;
            end
            if (state == ST_ADDR)      wait_cnt <= WAIT_M1;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (state == ST_CAPT) begin
                wr_en    <= dec_match;
                wr_addr  <= dec_local;
                wr_data  <= rom_d;
                checksum <= checksum + 16'(rom_d);
                if (!last_addr) dl_addr <= dl_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader: three configurations run in parallel against
// a range-table reference model of region mapping, ROM contents and checksum.
`timescale 1ns/1ps
module tb_rom_loader;

    localparam int N_A = 'h2000;

    logic clk_6144 = 1'b0;
    always #5 clk_6144 = ~clk_6144;

    int cyc = 0;
    always @(posedge clk_6144) cyc <= cyc + 1;

    // ---------------- instance A: byte = addr[7:0], 1 wait state
    logic        a_reset, a_start, a_busy, a_done;
    logic [18:0] a_cpu_a, a_rom_a;
    logic [7:0]  a_rom_d, a_wr_data, a_wr_en;
    logic [13:0] a_wr_addr;
    logic [15:0] a_cks;
    assign a_rom_d = a_rom_a[7:0];

    rom_loader #(
        .ADDR_W(19), .DATA_W(8), .NUM_REG(8),
        .REG_BASE({19'h0, 19'h0, 19'h0, 19'h0, 19'h01000, 19'h00800, 19'h0, 19'h00000}),
        .REG_AW({5'd0, 5'd0, 5'd0, 5'd0, 5'd12, 5'd11, 5'd0, 5'd10}),
        .END_ADDR(19'h01FFF), .WAIT_CYC(1), .AUTO_START(1)
    ) u_a (
        .clk_6144(clk_6144), .reset(a_reset), .start(a_start), .cpu_a(a_cpu_a),
        .rom_a(a_rom_a), .rom_d(a_rom_d), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_en(a_wr_en), .busy(a_busy), .done(a_done), .checksum(a_cks)
    );

    // ---------------- instance B: random ROM with 3-cycle latency, 3 wait states
    logic        b_reset, b_start, b_busy, b_done;
    logic [9:0]  b_cpu_a, b_rom_a, b_p1, b_p2, b_p3;
    logic [7:0]  b_rom_d, b_wr_data;
    logic [1:0]  b_wr_en;
    logic [13:0] b_wr_addr;
    logic [15:0] b_cks;
    logic [7:0]  mem_b [1024];
    always @(posedge clk_6144) begin
        b_p1 <= b_rom_a;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign b_rom_d = mem_b[b_p3];

    rom_loader #(
        .ADDR_W(10), .DATA_W(8), .NUM_REG(2),
        .REG_BASE({10'h200, 10'h000}), .REG_AW({5'd9, 5'd9}),
        .END_ADDR(10'h3FF), .WAIT_CYC(3), .AUTO_START(1)
    ) u_b (
        .clk_6144(clk_6144), .reset(b_reset), .start(b_start), .cpu_a(b_cpu_a),
        .rom_a(b_rom_a), .rom_d(b_rom_d), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_en(b_wr_en), .busy(b_busy), .done(b_done), .checksum(b_cks)
    );

    // ---------------- instance C: overlapping regions, all-0xFF ROM, manual start
    logic        c_reset, c_start, c_busy, c_done;
    logic [11:0] c_cpu_a, c_rom_a;
    logic [7:0]  c_rom_d, c_wr_data;
    logic [1:0]  c_wr_en;
    logic [13:0] c_wr_addr;
    logic [15:0] c_cks;
    assign c_rom_d = 8'hFF;

    rom_loader #(
        .ADDR_W(12), .DATA_W(8), .NUM_REG(2),
        .REG_BASE({12'h000, 12'h000}), .REG_AW({5'd12, 5'd10}),
        .END_ADDR(12'hFFF), .WAIT_CYC(0), .AUTO_START(0)
    ) u_c (
        .clk_6144(clk_6144), .reset(c_reset), .start(c_start), .cpu_a(c_cpu_a),
        .rom_a(c_rom_a), .rom_d(c_rom_d), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .wr_en(c_wr_en), .busy(c_busy), .done(c_done), .checksum(c_cks)
    );

    // ---------------- reference model
    int lo [3][8];
    int hi [3][8];
    int end_of [3];
    int exp_cks [3];
    int nxt [3];
    int bad [3];
    int strobes [3][8];
    int b_last_t = -1;
    int b_gap_bad = 0;
    logic a_busy_q = 1'b0, b_busy_q = 1'b0, c_busy_q = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_region(input int k, input int a);
        for (int i = 0; i < 8; i++)
            if (a >= lo[k][i] && a < hi[k][i]) return i;
        return -1;
    endfunction

    function automatic int rom_byte(input int k, input int a);
        if (k == 0) return a % 256;
        if (k == 1) return int'(mem_b[a]);
        return 255;
    endfunction

    // Each strobe must be the next address (in load order) that has a region.
    task automatic sb_event(input int k, input int en, input int addr, input int data);
        int a, r;
        a = nxt[k];
        r = -1;
        while (a <= end_of[k]) begin
            r = exp_region(k, a);
            if (r >= 0) break;
            a++;
        end
        if (r < 0 || en != (1 << r) || addr != a - lo[k][r] || data != rom_byte(k, a))
            bad[k]++;
        else
            strobes[k][r]++;
        nxt[k] = a + 1;
    endtask

    always @(negedge clk_6144) begin
        if (a_busy && !a_busy_q) nxt[0] = 0;
        a_busy_q = a_busy;
        if (a_wr_en != 0) sb_event(0, int'(a_wr_en), int'(a_wr_addr), int'(a_wr_data));
    end

    always @(negedge clk_6144) begin
        if (b_busy && !b_busy_q) nxt[1] = 0;
        b_busy_q = b_busy;
        if (b_wr_en != 0) begin
            sb_event(1, int'(b_wr_en), int'(b_wr_addr), int'(b_wr_data));
            if (b_last_t >= 0 && cyc - b_last_t != 5) b_gap_bad++;
            b_last_t = cyc;
        end
    end

    always @(negedge clk_6144) begin
        if (c_busy && !c_busy_q) nxt[2] = 0;
        c_busy_q = c_busy;
        if (c_wr_en != 0) sb_event(2, int'(c_wr_en), int'(c_wr_addr), int'(c_wr_data));
    end

    // ---------------- stimulus
    initial begin
        a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_cpu_a = 19'h7FFFF; b_cpu_a = '0; c_cpu_a = '0;
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom);
        for (int k = 0; k < 3; k++) begin
            nxt[k] = 0; bad[k] = 0;
            for (int i = 0; i < 8; i++) begin
                lo[k][i] = 0; hi[k][i] = 0; strobes[k][i] = 0;
            end
        end
        lo[0][0] = 'h000;  hi[0][0] = 'h400;
        lo[0][2] = 'h800;  hi[0][2] = 'h1000;
        lo[0][3] = 'h1000; hi[0][3] = 'h2000;
        lo[1][0] = 'h000;  hi[1][0] = 'h200;
        lo[1][1] = 'h200;  hi[1][1] = 'h400;
        lo[2][0] = 'h000;  hi[2][0] = 'h400;
        lo[2][1] = 'h000;  hi[2][1] = 'h1000;
        end_of[0] = N_A - 1; end_of[1] = 'h3FF; end_of[2] = 'hFFF;
        for (int k = 0; k < 3; k++) begin
            exp_cks[k] = 0;
            for (int a = 0; a <= end_of[k]; a++) exp_cks[k] += rom_byte(k, a);
            exp_cks[k] = exp_cks[k] % 65536;
        end

        @(negedge clk_6144);
        fork
            begin : thr_a
                int t, n1, n2;
                logic [18:0] mid;
                check("a_rst_ctrl", {a_busy, a_done, a_wr_en}, 0);
                check("a_rst_data", {a_wr_addr, a_wr_data, a_cks}, 0);
                check("a_rst_rom_a_cpu", a_rom_a, 19'h7FFFF);
                a_reset = 1'b0;
                t = cyc;
                for (int i = 0; i < 4*N_A && !a_done; i++) @(negedge clk_6144);
                check("a_done_within_4n", a_done, 1);
                n1 = cyc - t;
                @(negedge clk_6144);
                check("a_cks_pass1", a_cks, exp_cks[0]);
                check("a_stream_pass1", bad[0], 0);
                check("a_reg0_count", strobes[0][0], 'h400);
                check("a_reg2_count", strobes[0][2], 'h800);
                check("a_reg3_count", strobes[0][3], 'h1000);
                a_cpu_a = 19'h1234;
                #1 check("a_cpu_a_passthru", a_rom_a, 19'h1234);

                for (int i = 0; i < 8; i++) strobes[0][i] = 0;
                @(negedge clk_6144);
                a_start = 1'b1;
                t = cyc;
                @(negedge clk_6144);
                a_start = 1'b0;
                check("a_done_clr_on_start", {a_done, a_busy}, 2'b01);
                mid = 19'($urandom_range(16, 'h1F00));
                for (int i = 0; i < 4*N_A && !(a_busy && a_rom_a == mid); i++) @(negedge clk_6144);
                check("a_reach_mid", a_rom_a, mid);
                a_start = 1'b1;
                @(negedge clk_6144);
                a_start = 1'b0;
                check("a_midstart_ignored", {a_busy, 1'(a_rom_a >= mid)}, 2'b11);
                for (int i = 0; i < 4*N_A && !a_done; i++) @(negedge clk_6144);
                n2 = cyc - t;
                check("a_done_pass2", a_done, 1);
                check("a_pass2_cycles", n2, n1);
                @(negedge clk_6144);
                check("a_cks_pass2", a_cks, exp_cks[0]);
                check("a_stream_pass2", bad[0], 0);
                check("a_reg3_count2", strobes[0][3], 'h1000);

                a_start = 1'b1;
                @(negedge clk_6144);
                a_start = 1'b0;
                for (int i = 0; i < 4*N_A && !(a_busy && a_rom_a == 19'h1123); i++) @(negedge clk_6144);
                check("a_reach_1123", a_rom_a, 19'h1123);
                #1 a_reset = 1'b1;
                #1;
                check("a_midrst_ctrl", {a_busy, a_done, a_wr_en}, 0);
                check("a_midrst_data", {a_wr_addr, a_wr_data, a_cks}, 0);
                @(negedge clk_6144);
                a_reset = 1'b0;
                for (int i = 0; i < 100 && a_wr_en == 0; i++) @(negedge clk_6144);
                check("a_first_wr_after_rst", {a_wr_en, a_wr_addr, a_wr_data}, {8'h01, 14'h0, 8'h00});
            end
            begin : thr_b
                logic [9:0] ca;
                check("b_rst_outs", {b_busy, b_done, b_wr_en, b_wr_addr, b_wr_data, b_cks}, 0);
                b_reset = 1'b0;
                for (int i = 0; i < 6*1024 && !b_done; i++) @(negedge clk_6144);
                check("b_done", b_done, 1);
                @(negedge clk_6144);
                check("b_cks", b_cks, exp_cks[1]);
                check("b_stream", bad[1], 0);
                check("b_period_5", b_gap_bad, 0);
                repeat (20) @(negedge clk_6144);
                check("b_no_wrap", {b_done, 32'(strobes[1][0] + strobes[1][1])}, {1'b1, 32'h400});
                ca = 10'($urandom);
                b_cpu_a = ca;
                #1 check("b_cpu_a_passthru", b_rom_a, ca);
            end
            begin : thr_c
                c_reset = 1'b0;
                repeat (20) @(negedge clk_6144);
                check("c_idle_no_auto", {c_busy, c_done, c_wr_en}, 0);
                c_start = 1'b1;
                @(negedge clk_6144);
                c_start = 1'b0;
                check("c_busy_on_start", c_busy, 1);
                for (int i = 0; i < 3*4096 && !c_done; i++) @(negedge clk_6144);
                check("c_done", c_done, 1);
                @(negedge clk_6144);
                check("c_cks", c_cks, exp_cks[2]);
                check("c_stream", bad[2], 0);
                check("c_reg0_low_only", strobes[2][0], 'h400);
                check("c_reg1_rest", strobes[2][1], 'hC00);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
